// File: rtl/irq_controller.sv
// irq_controller: parametrised interrupt controller with input synchronisers,
// edge/level request latching, per-channel enables, fixed-priority
// arbitration and an ack/EOI handshake toward the cpu. Exposes four 8-bit
// registers (ENABLE, MODE, PENDING, CTRL) on the data-memory/IO bus.
module irq_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int VEC_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [1:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    input  logic               reg_we,
    input  logic               reg_re,
    output logic [7:0]         reg_rdata,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vector,
    input  logic               irq_ack,
    output logic               in_service
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    logic [NUM_IRQ-1:0] sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_last;
    logic [NUM_IRQ-1:0] level;
    logic [NUM_IRQ-1:0] rise;

    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_next;
    logic               gie;

    logic [1:0]         state;
    logic [NUM_IRQ-1:0] cand;
    logic               any_cand;
    logic [VEC_W-1:0]   win;
    logic               vec_cand;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] w1c;

    logic               wr_enable;
    logic               wr_mode;
    logic               wr_pending;
    logic               wr_ctrl;
    logic               ack_fire;
    logic               eoi_fire;
    logic [7:0]         rd_mux;

    // Zero-extend a channel vector to the 8-bit register width.
    function automatic logic [7:0] pad8(input logic [NUM_IRQ-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    assign wr_enable  = reg_we && (reg_addr == ADDR_ENABLE);
    assign wr_mode    = reg_we && (reg_addr == ADDR_MODE);
    assign wr_pending = reg_we && (reg_addr == ADDR_PENDING);
    assign wr_ctrl    = reg_we && (reg_addr == ADDR_CTRL);
    assign ack_fire   = irq_ack && (state == ST_REQ);
    assign eoi_fire   = wr_ctrl && reg_wdata[1] && (state == ST_SVC);

    assign irq_req    = (state == ST_REQ);
    assign in_service = (state == ST_SVC);

    // Multi-flop synchroniser chain for the asynchronous request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync[s] <= '0;
            end
        end else begin
            sync[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync[s] <= sync[s-1];
            end
        end
    end

    // History of the synchroniser output, so a rise is seen once per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_last <= '0;
        end else begin
            sync_last <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~sync_last;
    assign w1c   = wr_pending ? reg_wdata[NUM_IRQ-1:0] : '0;

    // Pending next-state: edge channels set-over-clear, level channels follow the line.
    always_comb begin
        pending_next = (mode & ((pending & ~(w1c | ack_clr)) | rise))
                     | (~mode & level);
    end

    // Candidate selection: lowest index wins; also look up the latched channel.
    always_comb begin
        cand     = gie ? (pending & enable) : '0;
        any_cand = |cand;
        win      = '0;
        vec_cand = 1'b0;
        ack_clr  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win = VEC_W'(i);
            end
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_vector == VEC_W'(i)) begin
                vec_cand   = cand[i];
                ack_clr[i] = ack_fire;
            end
        end
    end

    // Control registers and the pending vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable  <= '0;
            mode    <= '0;
            gie     <= 1'b0;
            pending <= '0;
        end else begin
            if (wr_enable) begin
                enable <= reg_wdata[NUM_IRQ-1:0];
            end
            if (wr_mode) begin
                mode <= reg_wdata[NUM_IRQ-1:0];
            end
            if (wr_ctrl) begin
                gie <= reg_wdata[0];
            end
            pending <= pending_next;
        end
    end

    // Request handshake FSM; the vector is latched once and held until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            irq_vector <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_cand) begin
                        state      <= ST_REQ;
                        irq_vector <= win;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state <= ST_SVC;
                    end else if (!vec_cand) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SVC: begin
                    if (eoi_fire) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register read mux; EOI is write-only so CTRL bit1 reads 0.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_ENABLE:  rd_mux = pad8(enable);
            ADDR_MODE:    rd_mux = pad8(mode);
            ADDR_PENDING: rd_mux = pad8(pending);
            ADDR_CTRL:    rd_mux = {5'b0, in_service, 1'b0, gie};
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, held when no read strobe is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata <= '0;
        end else if (reg_re) begin
            reg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed handshake scenarios followed by randomized
// edge-mode bursts whose service order comes from a queue-based model.
module tb_irq_controller;

    localparam int NUM_IRQ     = 8;
    localparam int VEC_W       = 3;
    localparam int SYNC_STAGES = 2;

    logic               clk;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic [1:0]         reg_addr;
    logic [7:0]         reg_wdata;
    logic               reg_we;
    logic               reg_re;
    logic [7:0]         reg_rdata;
    logic               irq_req;
    logic [VEC_W-1:0]   irq_vector;
    logic               irq_ack;
    logic               in_service;

    int checks = 0;
    int errors = 0;

    irq_controller #(
        .NUM_IRQ    (NUM_IRQ),
        .VEC_W      (VEC_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .irq_req   (irq_req),
        .irq_vector(irq_vector),
        .irq_ack   (irq_ack),
        .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        reg_addr = a;
        reg_re   = 1'b1;
        tick();
        reg_re   = 1'b0;
        d        = reg_rdata;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int limit);
        int n;
        n = 0;
        while (irq_req !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, irq_req}, 32'd1);
    endtask

    task automatic pulse(input logic [NUM_IRQ-1:0] m);
        irq_in = irq_in | m;
        repeat (3) tick();
        irq_in = irq_in & ~m;
    endtask

    logic [7:0] d;
    int         n;
    int         expq[$];
    logic [7:0] p;
    logic [7:0] en;

    initial begin
        irq_in    = '0;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        irq_ack   = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        chk("reset_irq_req", {31'b0, irq_req}, 0);
        chk("reset_in_service", {31'b0, in_service}, 0);
        chk("reset_rdata", {24'b0, reg_rdata}, 0);
        chk("reset_vector", {29'b0, irq_vector}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("reset_reg%0d", a), {24'b0, d}, 0);
        end

        // Single edge-mode channel, exact request latency.
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h01);
        wr(2'd3, 8'h01);
        irq_in[0] = 1'b1;
        n = 0;
        while (irq_req !== 1'b1 && n < 12) begin
            tick();
            n++;
            if (n == 3) irq_in[0] = 1'b0;
        end
        irq_in[0] = 1'b0;
        chk("t1_latency", n, SYNC_STAGES + 2);
        chk("t1_vector", {29'b0, irq_vector}, 0);
        ack();
        chk("t1_req_after_ack", {31'b0, irq_req}, 0);
        chk("t1_insvc_after_ack", {31'b0, in_service}, 1);
        rd(2'd2, d);
        chk("t1_pending_cleared", {24'b0, d}, 0);
        rd(2'd3, d);
        chk("t1_ctrl_read", {24'b0, d}, 32'h05);
        wr(2'd3, 8'h03);
        chk("t1_insvc_after_eoi", {31'b0, in_service}, 0);
        repeat (3) tick();
        chk("t1_no_rerequest", {31'b0, irq_req}, 0);

        // Two edge channels pulsed together: priority then re-request after EOI.
        wr(2'd1, 8'h24);
        wr(2'd0, 8'h24);
        wr(2'd2, 8'hFF);
        pulse(8'h24);
        wait_req("t2_first_req", 10);
        chk("t2_first_vector", {29'b0, irq_vector}, 2);
        ack();
        wr(2'd3, 8'h03);
        chk("t2_gap_after_eoi", {31'b0, irq_req}, 0);
        tick();
        chk("t2_second_req", {31'b0, irq_req}, 1);
        chk("t2_second_vector", {29'b0, irq_vector}, 5);
        ack();
        wr(2'd3, 8'h03);

        // Level channel 3: re-request while held, then withdraw during REQ.
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h08);
        irq_in[3] = 1'b1;
        wait_req("t3_req", 10);
        chk("t3_vector", {29'b0, irq_vector}, 3);
        ack();
        chk("t3_insvc", {31'b0, in_service}, 1);
        wr(2'd3, 8'h03);
        tick();
        chk("t3_rerequest", {31'b0, irq_req}, 1);
        chk("t3_rerequest_vector", {29'b0, irq_vector}, 3);
        irq_in[3] = 1'b0;
        n = 0;
        while (irq_req !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("t3_withdraw", {31'b0, irq_req}, 0);
        chk("t3_withdraw_insvc", {31'b0, in_service}, 0);
        repeat (3) tick();
        chk("t3_stays_idle", {31'b0, irq_req}, 0);

        // Pending with enable off, then set-wins on simultaneous W1C and edge.
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h00);
        wr(2'd2, 8'hFF);
        pulse(8'h01);
        repeat (5) tick();
        chk("t4_masked_req", {31'b0, irq_req}, 0);
        rd(2'd2, d);
        chk("t4_pending_masked", {24'b0, d}, 32'h01);
        wr(2'd0, 8'h01);
        wait_req("t4_enable_req", 6);
        chk("t4_vector", {29'b0, irq_vector}, 0);
        ack();
        wr(2'd3, 8'h03);
        wr(2'd0, 8'h00);
        pulse(8'h01);
        repeat (5) tick();
        irq_in[0] = 1'b1;
        repeat (SYNC_STAGES) tick();
        wr(2'd2, 8'h01);
        rd(2'd2, d);
        chk("t4_set_wins", {24'b0, d}, 32'h01);
        wr(2'd2, 8'h01);
        rd(2'd2, d);
        chk("t4_w1c_clears", {24'b0, d}, 32'h00);
        irq_in[0] = 1'b0;
        repeat (3) tick();

        // Global enable gating, ack and EOI ignored while IDLE.
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h01);
        pulse(8'h01);
        repeat (5) tick();
        chk("t5_gie_off", {31'b0, irq_req}, 0);
        ack();
        chk("t5_ack_idle_req", {31'b0, irq_req}, 0);
        chk("t5_ack_idle_insvc", {31'b0, in_service}, 0);
        rd(2'd2, d);
        chk("t5_ack_idle_pending", {24'b0, d}, 32'h01);
        wr(2'd3, 8'h02);
        chk("t5_eoi_idle_insvc", {31'b0, in_service}, 0);
        chk("t5_eoi_idle_req", {31'b0, irq_req}, 0);
        wr(2'd3, 8'h01);
        wait_req("t5_gie_on_req", 4);
        chk("t5_vector", {29'b0, irq_vector}, 0);

        // Asynchronous reset in the middle of REQ.
        rd(2'd0, d);
        chk("t6_pre_reset_rdata", {24'b0, d}, 32'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_req_rst_req", {31'b0, irq_req}, 0);
        chk("t6_req_rst_insvc", {31'b0, in_service}, 0);
        chk("t6_req_rst_rdata", {24'b0, reg_rdata}, 0);
        chk("t6_req_rst_vector", {29'b0, irq_vector}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("t6_req_rst_reg%0d", a), {24'b0, d}, 0);
        end

        // Asynchronous reset in the middle of SVC.
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h01);
        wr(2'd3, 8'h01);
        pulse(8'h01);
        wait_req("t6_svc_req", 8);
        ack();
        rd(2'd3, d);
        chk("t6_svc_ctrl", {24'b0, d}, 32'h05);
        rst_n = 1'b0;
        #1;
        chk("t6_svc_rst_insvc", {31'b0, in_service}, 0);
        chk("t6_svc_rst_rdata", {24'b0, reg_rdata}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("t6_svc_rst_reg%0d", a), {24'b0, d}, 0);
        end

        // Randomized bursts: service order is the ascending list of enabled pulsed channels.
        wr(2'd1, 8'hFF);
        for (int t = 0; t < 10; t++) begin
            wr(2'd3, 8'h00);
            wr(2'd2, 8'hFF);
            p  = 8'($urandom_range(1, 255));
            en = 8'($urandom);
            wr(2'd0, en);
            pulse(p);
            repeat (4) tick();
            rd(2'd2, d);
            chk($sformatf("rnd%0d_pending", t), {24'b0, d}, {24'b0, p});
            expq.delete();
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (p[i] && en[i]) expq.push_back(i);
            end
            wr(2'd3, 8'h01);
            while (expq.size() > 0) begin
                wait_req($sformatf("rnd%0d_req", t), 6);
                chk($sformatf("rnd%0d_vector", t), {29'b0, irq_vector}, expq.pop_front());
                repeat ($urandom_range(0, 2)) tick();
                ack();
                chk($sformatf("rnd%0d_insvc", t), {31'b0, in_service}, 1);
                repeat ($urandom_range(0, 2)) tick();
                wr(2'd3, 8'h03);
            end
            repeat (3) tick();
            chk($sformatf("rnd%0d_idle", t), {31'b0, irq_req}, 0);
            rd(2'd2, d);
            chk($sformatf("rnd%0d_leftover", t), {24'b0, d}, {24'b0, p & ~en});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
